// File: rtl/shift_reg_univ.sv
// Universal shift register: load, shift, rotate, arithmetic shift, clear.
// Counts shifts since the last load/clear/reset and pulses when it fills.
module shift_reg_univ #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             shift_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_MAX = CW'(WIDTH);
  localparam logic [CW-1:0] C_PRE = CW'(WIDTH - 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_shift;
  logic             w_zero;

  assign w_shift = en && (mode >= M_SHL) && (mode <= M_ASR);
  assign w_zero  = en && ((mode == M_LOAD) || (mode == M_CLR));

  // Next data and serial-out for the selected operation.
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    if (en) begin
      unique case (mode)
        M_HOLD: w_q_nxt = r_q;
        M_LOAD: w_q_nxt = d;
        M_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin};
          w_sout_nxt = r_q[WIDTH-1];
        end
        M_SHR: begin
          w_q_nxt    = {sin, r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        M_ROL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_nxt = r_q[WIDTH-1];
        end
        M_ROR: begin
          w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        M_ASR: begin
          w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        M_CLR: w_q_nxt = RST_VAL;
        default: w_q_nxt = r_q;
      endcase
    end
  end

  // Saturating shift counter; the pulse fires only on the fill edge.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (w_zero) begin
      w_cnt_nxt = '0;
    end else if (w_shift && (r_cnt != C_MAX)) begin
      w_cnt_nxt  = r_cnt + 1'b1;
      w_done_nxt = (r_cnt == C_PRE);
    end
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RST_VAL;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign q          = r_q;
  assign sout       = r_sout;
  assign shift_done = r_done;

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default 0: WIDTH-bit value loaded into q on reset and on CLEAR.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  operation enable; 0 = hold all state.
REQ-006 mode  input  3  operation select, per REQ-010.
REQ-007 sin  input  1  serial data in for SHL and SHR.
REQ-008 d  input  WIDTH  parallel load data.
REQ-009 q  output  WIDTH  register contents, registered, plus sout (output, 1, last bit shifted out, registered) and shift_done (output, 1, registered one-cycle pulse).

Function
REQ-010 When en=1 and rst=0, mode SHALL select the following, with "q" meaning the value before the edge:
- 000 HOLD: q unchanged.
- 001 LOAD: q<=d.
- 010 SHL: q<={q[W-2:0],sin}.
- 011 SHR: q<={sin,q[W-1:1]}.
- 100 ROL: q<={q[W-2:0],q[W-1]}.
- 101 ROR: q<={q[0],q[W-1:1]}.
- 110 ASR: q<={q[W-1],q[W-1:1]}.
- 111 CLEAR: q<=RST_VAL.
REQ-011 sout SHALL update only on shift and rotate modes (010-110): it takes q[W-1] for SHL and ROL, and q[0] for SHR, ROR and ASR; in all other modes it holds.
REQ-012 An internal shift counter SHALL count shift and rotate operations (modes 010-110 with en=1) since the last reset, LOAD or CLEAR.
- It is clog2(WIDTH+1) bits wide.
- It saturates at WIDTH.
REQ-013 LOAD and CLEAR SHALL zero the shift counter on the same edge that updates q.
REQ-014 shift_done SHALL be 1 for exactly one cycle, following the edge on which the counter goes from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-015 While the counter is saturated, further shifts SHALL NOT re-pulse shift_done; the next pulse requires a LOAD, CLEAR or reset followed by WIDTH further shifts.
REQ-016 When en=0, q, sout and the counter SHALL hold and shift_done SHALL be 0 on the next cycle, regardless of mode, sin and d.
REQ-017 HOLD with en=1 SHALL hold q, sout and the counter, and drive shift_done to 0.
REQ-018 Latency SHALL be one clock from the inputs sampled at an edge to the resulting q, sout and shift_done.
REQ-019 Operations SHALL be back-to-back capable: a new mode is accepted every cycle, with no idle cycles required between modes.

Reset
REQ-020 When rst=1 at a rising edge: q<=RST_VAL, sout<=0, counter<=0, shift_done<=0.
REQ-021 rst SHALL take priority over en and mode, including when asserted in the middle of a shift sequence.
REQ-022 No state SHALL change asynchronously; before the first reset edge, outputs are undefined.

Verification (WIDTH=8, RST_VAL=0x00)
REQ-023 Reset then load: rst=1 for 2 cycles -> q=0x00, sout=0, shift_done=0; then en=1, mode=LOAD, d=0xA5 -> q=0xA5 after 1 edge.
REQ-024 Rotate: LOAD 0x81, then ROL -> q=0x03, sout=1; then ROR -> q=0x81, sout=1.
REQ-025 Arithmetic and logical right shift:
- LOAD 0x80, ASR x2 -> q=0xC0 then 0xE0, sout=0 both.
- LOAD 0x01, SHR with sin=0 -> q=0x00, sout=1.
REQ-026 Fill and done:
- LOAD 0x00, SHL with sin=1 for 8 cycles -> q=0xFF and shift_done=1 for exactly the cycle after the 8th edge.
- 9th and 10th shifts -> shift_done stays 0.
- LOAD, then 8 more shifts -> a single pulse again.
REQ-027 Enable gating: LOAD 0x3C, then en=0 with mode=SHL, sin=1 for 5 cycles -> q=0x3C, sout and counter unchanged, shift_done=0.
REQ-028 Reset mid-operation:
- After 5 SHLs, assert rst for 1 cycle -> q=0x00, counter 0.
- After release, the 8th subsequent shift (not the 3rd) -> shift_done pulse.
